uart_rx_fifo: RTL and testbench

//  Byte buffer directly downstream of the UART receiver. Captures each one-cycle
//  i_Rx_DV strobe with its i_Rx_Byte into a circular FIFO and presents bytes on a

---
 rtl/uart_rx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT byte FIFO behind a UART receiver with overflow and idle-timeout flags
module uart_rx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int TIMEOUT_CLKS = 1000
) (
  input  logic                i_Clock,
  input  logic                i_Rst_n,
  input  logic                i_Rx_DV,
  input  logic [7:0]          i_Rx_Byte,
  output logic                o_Data_Valid,
  output logic [7:0]          o_Data,
  input  logic                i_Data_Ready,
  output logic [DEPTH_LOG2:0] o_Count,
  output logic                o_Full,
  output logic                o_Empty,
  output logic                o_Overflow,
  input  logic                i_Overflow_Clr,
  output logic                o_Timeout
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH    = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [15:0]         C_TMO_LAST = 16'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNTING,
    S_EXPIRED
  } state_t;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_next;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic                  r_timeout;
  state_t                r_state;
  state_t                w_state_next;
  logic [15:0]           r_tmo_cnt;
  logic [15:0]           w_tmo_cnt_next;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_pop  = !r_empty && i_Data_Ready;
  assign w_push = i_Rx_DV && (!r_full || w_pop);
  assign w_drop = i_Rx_DV && r_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (DEPTH_LOG2+1)'(1);
      2'b01:   w_count_next = r_count - (DEPTH_LOG2+1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_Rx_Byte;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == C_DEPTH);
      r_empty <= (w_count_next == '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_Overflow_Clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_next   = S_IDLE;
    w_tmo_cnt_next = '0;
    if (TIMEOUT_CLKS != 0) begin
      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            w_state_next = S_COUNTING;
          end
        end
        S_COUNTING: begin
          if (w_push) begin
            w_state_next = S_COUNTING;
          end else if (w_count_next == '0) begin
            w_state_next = S_IDLE;
          end else if (r_tmo_cnt == C_TMO_LAST) begin
            w_state_next = S_EXPIRED;
          end else begin
            w_state_next   = S_COUNTING;
            w_tmo_cnt_next = r_tmo_cnt + 16'd1;
          end
        end
        S_EXPIRED: begin
          if (w_push) begin
            w_state_next = S_COUNTING;
          end else if (w_count_next == '0) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_EXPIRED;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // The flag is loaded from the next-state decode so it always equals (r_state == S_EXPIRED).
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state   <= S_IDLE;
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_tmo_cnt <= w_tmo_cnt_next;
      r_timeout <= (w_state_next == S_EXPIRED);
    end
  end

  assign o_Data_Valid = !r_empty;
  assign o_Data       = r_mem[r_rd_ptr];
  assign o_Count      = r_count;
  assign o_Full       = r_full;
  assign o_Empty      = r_empty;
  assign o_Overflow   = r_overflow;
  assign o_Timeout    = r_timeout;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed table-driven bench for uart_rx_fifo (depth 4, timeout 8)
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       data_valid;
  logic [7:0] data;
  logic       data_ready;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       ovf_clr;
  logic       timeout;

  int n_checks;
  int n_errors;

  uart_rx_fifo #(
    .DEPTH_LOG2  (2),
    .TIMEOUT_CLKS(8)
  ) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_Rx_DV       (rx_dv),
    .i_Rx_Byte     (rx_byte),
    .o_Data_Valid  (data_valid),
    .o_Data        (data),
    .i_Data_Ready  (data_ready),
    .o_Count       (count),
    .o_Full        (full),
    .o_Empty       (empty),
    .o_Overflow    (overflow),
    .i_Overflow_Clr(ovf_clr),
    .o_Timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       dv;
    logic [7:0] din;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_data;
    logic [2:0] e_count;
    logic       e_full;
    logic       e_empty;
    logic       e_ovf;
    logic       e_tmo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic dv, input logic [7:0] din, input logic rdy,
                     input logic clr, input logic ev, input logic [7:0] ed, input logic [2:0] ec,
                     input logic ef, input logic ee, input logic eo, input logic et);
    vec_t v;
    v.name = n; v.dv = dv; v.din = din; v.rdy = rdy; v.clr = clr;
    v.e_valid = ev; v.e_data = ed; v.e_count = ec; v.e_full = ef;
    v.e_empty = ee; v.e_ovf = eo; v.e_tmo = et;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string n, input logic ev, input logic [7:0] ed, input logic [2:0] ec,
                         input logic ef, input logic ee, input logic eo, input logic et);
    chk({n, ".valid"}, 16'(data_valid), 16'(ev));
    if (ev) chk({n, ".data"}, 16'(data), 16'(ed));
    chk({n, ".count"}, 16'(count), 16'(ec));
    chk({n, ".full"}, 16'(full), 16'(ef));
    chk({n, ".empty"}, 16'(empty), 16'(ee));
    chk({n, ".overflow"}, 16'(overflow), 16'(eo));
    chk({n, ".timeout"}, 16'(timeout), 16'(et));
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    rx_dv      = 1'b0;
    rx_byte    = 8'h00;
    data_ready = 1'b0;
    ovf_clr    = 1'b0;

    //   name           dv  din    rdy clr | valid data  cnt full empty ovf tmo
    add("t1_push0",     1, 8'h11, 0, 0,   1, 8'h11, 3'd1, 0, 0, 0, 0);
    add("t1_push1",     1, 8'h22, 0, 0,   1, 8'h11, 3'd2, 0, 0, 0, 0);
    add("t1_push2",     1, 8'h33, 0, 0,   1, 8'h11, 3'd3, 0, 0, 0, 0);
    add("t1_pop0",      0, 8'h00, 1, 0,   1, 8'h22, 3'd2, 0, 0, 0, 0);
    add("t1_pop1",      0, 8'h00, 1, 0,   1, 8'h33, 3'd1, 0, 0, 0, 0);
    add("t1_pop2",      0, 8'h00, 1, 0,   0, 8'h00, 3'd0, 0, 1, 0, 0);
    add("t2_push0",     1, 8'hA0, 0, 0,   1, 8'hA0, 3'd1, 0, 0, 0, 0);
    add("t2_push1",     1, 8'hA1, 0, 0,   1, 8'hA0, 3'd2, 0, 0, 0, 0);
    add("t2_push2",     1, 8'hA2, 0, 0,   1, 8'hA0, 3'd3, 0, 0, 0, 0);
    add("t2_push3",     1, 8'hA3, 0, 0,   1, 8'hA0, 3'd4, 1, 0, 0, 0);
    add("t2_drop",      1, 8'hA4, 0, 0,   1, 8'hA0, 3'd4, 1, 0, 1, 0);
    add("t2_pop0",      0, 8'h00, 1, 0,   1, 8'hA1, 3'd3, 0, 0, 1, 0);
    add("t2_pop1",      0, 8'h00, 1, 0,   1, 8'hA2, 3'd2, 0, 0, 1, 0);
    add("t2_pop2",      0, 8'h00, 1, 0,   1, 8'hA3, 3'd1, 0, 0, 1, 0);
    add("t2_pop3",      0, 8'h00, 1, 0,   0, 8'h00, 3'd0, 0, 1, 1, 0);
    add("t2_clr",       0, 8'h00, 0, 1,   0, 8'h00, 3'd0, 0, 1, 0, 0);
    add("t3_push0",     1, 8'hB0, 0, 0,   1, 8'hB0, 3'd1, 0, 0, 0, 0);
    add("t3_push1",     1, 8'hB1, 0, 0,   1, 8'hB0, 3'd2, 0, 0, 0, 0);
    add("t3_push2",     1, 8'hB2, 0, 0,   1, 8'hB0, 3'd3, 0, 0, 0, 0);
    add("t3_push3",     1, 8'hB3, 0, 0,   1, 8'hB0, 3'd4, 1, 0, 0, 0);
    add("t3_setwin",    1, 8'hEE, 0, 1,   1, 8'hB0, 3'd4, 1, 0, 1, 0);
    add("t3_pushpop",   1, 8'hB5, 1, 1,   1, 8'hB1, 3'd4, 1, 0, 0, 0);
    add("t3_pop0",      0, 8'h00, 1, 0,   1, 8'hB2, 3'd3, 0, 0, 0, 0);
    add("t3_pop1",      0, 8'h00, 1, 0,   1, 8'hB3, 3'd2, 0, 0, 0, 0);
    add("t3_pop2",      0, 8'h00, 1, 0,   1, 8'hB5, 3'd1, 0, 0, 0, 0);
    add("t3_pop3",      0, 8'h00, 1, 0,   0, 8'h00, 3'd0, 0, 1, 0, 0);
    add("t4_nobypass",  1, 8'h5A, 1, 0,   1, 8'h5A, 3'd1, 0, 0, 0, 0);
    add("t4_pop",       0, 8'h00, 1, 0,   0, 8'h00, 3'd0, 0, 1, 0, 0);
    add("t4_rdy_empty", 0, 8'h00, 1, 0,   0, 8'h00, 3'd0, 0, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 8'h00, 3'd0, 0, 1, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      rx_dv      = vecs[i].dv;
      rx_byte    = vecs[i].din;
      data_ready = vecs[i].rdy;
      ovf_clr    = vecs[i].clr;
      step();
      chk_all(vecs[i].name, vecs[i].e_valid, vecs[i].e_data, vecs[i].e_count,
              vecs[i].e_full, vecs[i].e_empty, vecs[i].e_ovf, vecs[i].e_tmo);
    end
    rx_dv = 1'b0; data_ready = 1'b0; ovf_clr = 1'b0;

    // Timeout: rises on the 8th edge after the push edge, cleared by a new push.
    rx_dv = 1'b1; rx_byte = 8'h01;
    step();
    rx_dv = 1'b0;
    chk_all("t5_push01", 1, 8'h01, 3'd1, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("t5_idle%0d.timeout", k), 16'(timeout), 16'd0);
    end
    step();
    chk("t5_expired.timeout", 16'(timeout), 16'd1);
    chk("t5_expired.data", 16'(data), 16'h01);
    rx_dv = 1'b1; rx_byte = 8'h02;
    step();
    rx_dv = 1'b0;
    chk_all("t5_push02", 1, 8'h01, 3'd2, 0, 0, 0, 0);
    data_ready = 1'b1;
    step();
    chk_all("t5_pop01", 1, 8'h02, 3'd1, 0, 0, 0, 0);
    step();
    data_ready = 1'b0;
    chk_all("t5_pop02", 0, 8'h00, 3'd0, 0, 1, 0, 0);
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("t5_drained%0d.timeout", k), 16'(timeout), 16'd0);
    end

    // Asynchronous reset with 3 bytes buffered and overflow set.
    for (int k = 0; k < 5; k++) begin
      rx_dv = 1'b1; rx_byte = 8'hC0 + 8'(k);
      step();
    end
    rx_dv = 1'b0; data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    chk_all("t6_pre", 1, 8'hC1, 3'd3, 0, 0, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("t6_async_rst", 0, 8'h00, 3'd0, 0, 1, 0, 0);
    #2;
    rst_n = 1'b1;
    rx_dv = 1'b1; rx_byte = 8'h77;
    step();
    rx_dv = 1'b0;
    chk_all("t6_push77", 1, 8'h77, 3'd1, 0, 0, 0, 0);
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    chk_all("t6_pop77", 0, 8'h00, 3'd0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
